// File: rtl/mux_share_pkg.sv
// Shared types and defaults for the Mux8 time-sharing arbiter.
// State encoding is fixed at 2 bits so it can be shown directly on debug LEDs.
package mux_share_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2,
    ST_GAP  = 2'd3
  } state_e;

  localparam int unsigned DEFAULT_MAX_HOLD = 16;

endpackage

// File: rtl/mux_share_arbiter.sv
// Two-requester round-robin arbiter owning the Mux8 select line.
// Bounded hold time, one dead cycle on every ownership change, all outputs registered.
module mux_share_arbiter
  import mux_share_pkg::*;
#(
  parameter int unsigned MAX_HOLD = DEFAULT_MAX_HOLD,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic [1:0]       Req,
  output logic [1:0]       Gnt,
  output logic             Sel,
  output logic             Valid,
  output logic [CNT_W-1:0] HoldCnt
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_e           state_q, state_d;
  logic             last_q, last_d;
  logic             sel_d;
  logic [CNT_W-1:0] cnt_d;
  logic             owner;
  logic             pick;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = HoldCnt;
    sel_d   = Sel;
    pick    = 1'b0;
    owner   = (state_q == ST_OWN1);

    unique case (state_q)
      // GAP is a one-cycle hold-off; on leaving it the IDLE rules decide the next owner.
      ST_IDLE, ST_GAP: begin
        if (Req != 2'b00) begin
          pick    = (Req == 2'b11) ? ~last_q : Req[1];
          state_d = pick ? ST_OWN1 : ST_OWN0;
          cnt_d   = '0;
          sel_d   = pick;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_OWN0, ST_OWN1: begin
        if (!Req[owner] || (Req[~owner] && (HoldCnt == HOLD_LAST))) begin
          state_d = ST_GAP;
          last_d  = owner;
        end else if (HoldCnt != HOLD_LAST) begin
          cnt_d = HoldCnt + CNT_W'(1);
        end
      end
    endcase
  end

  // Outputs are decoded from the next state and registered, so Req never reaches them combinationally.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
      Gnt     <= 2'b00;
      Sel     <= 1'b0;
      Valid   <= 1'b0;
      HoldCnt <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state_q <= state_d;
      last_q  <= last_d;
      Gnt     <= {state_d == ST_OWN1, state_d == ST_OWN0};
      Sel     <= sel_d;
      Valid   <= (state_d == ST_OWN0) || (state_d == ST_OWN1);
      HoldCnt <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mux_share_arbiter.sv
// Directed, table-driven bench for mux_share_arbiter with MAX_HOLD=4,
// plus hand sequences for async reset and a random run checking invariants.
module tb_mux_share_arbiter;

  localparam int MAX_HOLD = 4;
  localparam int CNT_W    = 8;

  logic             Clock;
  logic             Resetn;
  logic [1:0]       Req;
  logic [1:0]       Gnt;
  logic             Sel;
  logic             Valid;
  logic [CNT_W-1:0] HoldCnt;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [1:0] req;
    logic [1:0] gnt;
    logic       sel;
    logic       valid;
    int         cnt;   // -1: HoldCnt not checked on this step
  } vec_t;

  vec_t vecs[$];

  mux_share_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
    .Clock   (Clock),
    .Resetn  (Resetn),
    .Req     (Req),
    .Gnt     (Gnt),
    .Sel     (Sel),
    .Valid   (Valid),
    .HoldCnt (HoldCnt)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt"},   32'(Gnt),     32'h0);
    check({tag, "_sel"},   32'(Sel),     32'h0);
    check({tag, "_valid"}, 32'(Valid),   32'h0);
    check({tag, "_cnt"},   32'(HoldCnt), 32'h0);
  endtask

  // Drop Resetn between edges, confirm outputs clear immediately, release before the next edge.
  task automatic async_reset(input string tag);
    @(posedge Clock);
    #3 Resetn = 1'b0;
    #1 check_reset_outputs(tag);
    #2 Resetn = 1'b1;
  endtask

  task automatic step(input logic [1:0] r);
    Req = r;
    @(posedge Clock);
    #1;
  endtask

  initial begin
    int wait_cnt [2];
    logic       prev_sel;
    logic [1:0] prev_gnt;

    Resetn = 1'b0;
    Req    = 2'b00;

    // Tie from reset, alternating 4-cycle grants with one dead cycle, release, early handoff.
    vecs.push_back('{2'b11, 2'b01, 1'b0, 1'b1,  0});
    vecs.push_back('{2'b11, 2'b01, 1'b0, 1'b1,  1});
    vecs.push_back('{2'b11, 2'b01, 1'b0, 1'b1,  2});
    vecs.push_back('{2'b11, 2'b01, 1'b0, 1'b1,  3});
    vecs.push_back('{2'b11, 2'b00, 1'b0, 1'b0, -1});
    vecs.push_back('{2'b11, 2'b10, 1'b1, 1'b1,  0});
    vecs.push_back('{2'b11, 2'b10, 1'b1, 1'b1,  1});
    vecs.push_back('{2'b11, 2'b10, 1'b1, 1'b1,  2});
    vecs.push_back('{2'b11, 2'b10, 1'b1, 1'b1,  3});
    vecs.push_back('{2'b11, 2'b00, 1'b1, 1'b0, -1});
    vecs.push_back('{2'b11, 2'b01, 1'b0, 1'b1,  0});
    vecs.push_back('{2'b00, 2'b00, 1'b0, 1'b0, -1});
    vecs.push_back('{2'b00, 2'b00, 1'b0, 1'b0, -1});
    vecs.push_back('{2'b01, 2'b01, 1'b0, 1'b1,  0});
    vecs.push_back('{2'b01, 2'b01, 1'b0, 1'b1,  1});
    vecs.push_back('{2'b10, 2'b00, 1'b0, 1'b0, -1});
    vecs.push_back('{2'b10, 2'b10, 1'b1, 1'b1,  0});

    #12 check_reset_outputs("por");
    Resetn = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].req);
      check($sformatf("vec%0d_gnt", i),   32'(Gnt),   32'(vecs[i].gnt));
      check($sformatf("vec%0d_sel", i),   32'(Sel),   32'(vecs[i].sel));
      check($sformatf("vec%0d_valid", i), 32'(Valid), 32'(vecs[i].valid));
      if (vecs[i].cnt >= 0)
        check($sformatf("vec%0d_cnt", i), 32'(HoldCnt), 32'(vecs[i].cnt));
    end

    // Lone owner 1 keeps the grant; HoldCnt saturates at MAX_HOLD-1.
    for (int k = 1; k <= 40; k++) begin
      step(2'b10);
      check($sformatf("lone%0d_gnt", k), 32'(Gnt), 32'h2);
      check($sformatf("lone%0d_cnt", k), 32'(HoldCnt), 32'((k < MAX_HOLD - 1) ? k : MAX_HOLD - 1));
    end

    // Late competitor preempts the saturated owner on the next edge.
    step(2'b11);
    check("late_gap_gnt", 32'(Gnt), 32'h0);
    check("late_gap_valid", 32'(Valid), 32'h0);
    check("late_gap_sel", 32'(Sel), 32'h1);
    step(2'b11);
    check("late_own_gnt", 32'(Gnt), 32'h1);
    check("late_own_sel", 32'(Sel), 32'h0);
    check("late_own_cnt", 32'(HoldCnt), 32'h0);

    // Reset while owner 1 holds the mux: Sel must return to 0.
    step(2'b10);
    step(2'b10);
    check("pre_rst1_sel", 32'(Sel), 32'h1);
    async_reset("rst_own1");

    // Reset mid-grant of owner 0, then re-grant one cycle after release.
    for (int k = 0; k < 5; k++) step(2'b01);
    check("pre_rst0_gnt", 32'(Gnt), 32'h1);
    async_reset("rst_own0");
    step(2'b01);
    check("post_rst_gnt", 32'(Gnt), 32'h1);
    check("post_rst_valid", 32'(Valid), 32'h1);
    check("post_rst_cnt", 32'(HoldCnt), 32'h0);

    // Random request traffic with invariant and starvation checks.
    wait_cnt[0] = 0;
    wait_cnt[1] = 0;
    prev_sel = Sel;
    prev_gnt = Gnt;
    for (int c = 0; c < 10000; c++) begin
      logic [1:0] r;
      r = Req;
      for (int b = 0; b < 2; b++)
        if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
      step(r);
      check("rnd_not_both", 32'(Gnt == 2'b11), 32'h0);
      check("rnd_valid", 32'(Valid), 32'(Gnt != 2'b00));
      if (Sel !== prev_sel)
        check("rnd_sel_change", 32'((prev_gnt == 2'b00) && (Gnt != 2'b00)), 32'h1);
      for (int b = 0; b < 2; b++) begin
        wait_cnt[b] = (Req[b] && !Gnt[b]) ? wait_cnt[b] + 1 : 0;
        check($sformatf("rnd_starve%0d", b), 32'(wait_cnt[b] > MAX_HOLD + 2), 32'h0);
      end
      prev_sel = Sel;
      prev_gnt = Gnt;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
